// File: rtl/ras_stack.sv
// ras_stack: return address stack with push/pop/coroutine, wrap on overflow/underflow, checkpoint restore
module ras_stack #(
   parameter int RAS_DEPTH        = 8,
   parameter int RAS_TARGET_WIDTH = 12,
   parameter int LOG_RAS_DEPTH    = $clog2(RAS_DEPTH)
) (
   input  logic                        CLK,
   input  logic                        nRST,
   input  logic                        link_valid,
   input  logic [RAS_TARGET_WIDTH-1:0] link_target,
   input  logic                        ret_valid,
   output logic [RAS_TARGET_WIDTH-1:0] ret_target,
   output logic [LOG_RAS_DEPTH-1:0]    ras_index,
   output logic [LOG_RAS_DEPTH:0]      ras_count,
   output logic                        ras_empty,
   input  logic                        update_valid,
   input  logic [LOG_RAS_DEPTH-1:0]    update_ras_index,
   input  logic [LOG_RAS_DEPTH:0]      update_ras_count
);
   localparam logic [LOG_RAS_DEPTH:0] full_cnt = (LOG_RAS_DEPTH+1)'(RAS_DEPTH);
   logic [RAS_TARGET_WIDTH-1:0] stack [RAS_DEPTH];
   logic [LOG_RAS_DEPTH-1:0]    ptr, ptr_nxt, wr_idx;
   logic [LOG_RAS_DEPTH:0]      cnt, cnt_nxt;
   logic                        push, pop, wr_en;
   assign ret_target = stack[ptr];
   assign ras_index  = ptr;
   assign ras_count  = cnt;
   assign ras_empty  = (cnt == '0);
   always_comb begin
      push    = link_valid & ~ret_valid & ~update_valid;
      pop     = ret_valid & ~link_valid & ~update_valid;
      wr_en   = link_valid & ~update_valid;
      wr_idx  = ret_valid ? ptr : ptr + 1'b1;
      ptr_nxt = update_valid ? update_ras_index : push ? ptr + 1'b1 : pop ? ptr - 1'b1 : ptr;
      cnt_nxt = update_valid ? ((update_ras_count > full_cnt) ? full_cnt : update_ras_count) :
                push ? ((cnt == full_cnt) ? cnt : cnt + 1'b1) :
                pop  ? ((cnt == '0) ? cnt : cnt - 1'b1) : cnt;
   end
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ptr <= '0;
         cnt <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) stack[i] <= '0;
      end else begin
         ptr <= ptr_nxt;
         cnt <= cnt_nxt;
         if (wr_en) stack[wr_idx] <= link_target;
      end
   end
endmodule

// File: tb/tb_ras_stack.sv
// tb_ras_stack: directed tests for ras_stack
module tb_ras_stack;
   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        link_valid = 1'b0;
   logic [11:0] link_target = '0;
   logic        ret_valid = 1'b0;
   logic [11:0] ret_target;
   logic [2:0]  ras_index;
   logic [3:0]  ras_count;
   logic        ras_empty;
   logic        update_valid = 1'b0;
   logic [2:0]  update_ras_index = '0;
   logic [3:0]  update_ras_count = '0;
   int vec = 0;
   int err = 0;

   ras_stack dut (
      .CLK(CLK), .nRST(nRST),
      .link_valid(link_valid), .link_target(link_target), .ret_valid(ret_valid),
      .ret_target(ret_target), .ras_index(ras_index), .ras_count(ras_count), .ras_empty(ras_empty),
      .update_valid(update_valid), .update_ras_index(update_ras_index), .update_ras_count(update_ras_count)
   );

   always #5 CLK = ~CLK;

   task automatic cyc(input logic lv, input logic [11:0] lt, input logic rv);
      link_valid = lv;
      link_target = lt;
      ret_valid = rv;
      @(posedge CLK);
      #1;
      link_valid = 1'b0;
      ret_valid = 1'b0;
   endtask

   task automatic upd(input logic [2:0] idx, input logic [3:0] c, input logic lv, input logic rv);
      update_valid = 1'b1;
      update_ras_index = idx;
      update_ras_count = c;
      link_valid = lv;
      link_target = 12'hFFF;
      ret_valid = rv;
      @(posedge CLK);
      #1;
      update_valid = 1'b0;
      link_valid = 1'b0;
      ret_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      nRST = 1'b0;
      @(negedge CLK);
      nRST = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      vec++; if (ret_target !== 12'h000) begin err++; $display("FAIL reset_tgt got %h exp 000", ret_target); end
      vec++; if (ras_index !== 3'd0) begin err++; $display("FAIL reset_idx got %0d exp 0", ras_index); end
      vec++; if (ras_count !== 4'd0) begin err++; $display("FAIL reset_cnt got %0d exp 0", ras_count); end
      vec++; if (ras_empty !== 1'b1) begin err++; $display("FAIL reset_empty got %b exp 1", ras_empty); end
   endtask

   task automatic test_push_pop();
      do_reset();
      cyc(1'b1, 12'h111, 1'b0);
      cyc(1'b1, 12'h222, 1'b0);
      vec++; if (ret_target !== 12'h222) begin err++; $display("FAIL pp_push_tgt got %h exp 222", ret_target); end
      vec++; if (ras_count !== 4'd2) begin err++; $display("FAIL pp_push_cnt got %0d exp 2", ras_count); end
      vec++; if (ras_empty !== 1'b0) begin err++; $display("FAIL pp_empty got %b exp 0", ras_empty); end
      cyc(1'b0, 12'h000, 1'b1);
      vec++; if (ret_target !== 12'h111) begin err++; $display("FAIL pp_pop_tgt got %h exp 111", ret_target); end
      vec++; if (ras_count !== 4'd1) begin err++; $display("FAIL pp_pop_cnt got %0d exp 1", ras_count); end
      vec++; if (ras_index !== 3'd1) begin err++; $display("FAIL pp_pop_idx got %0d exp 1", ras_index); end
   endtask

   task automatic test_idle();
      repeat (3) cyc(1'b0, 12'h5A5, 1'b0);
      vec++; if (ret_target !== 12'h111) begin err++; $display("FAIL idle_tgt got %h exp 111", ret_target); end
      vec++; if (ras_index !== 3'd1) begin err++; $display("FAIL idle_idx got %0d exp 1", ras_index); end
      vec++; if (ras_count !== 4'd1) begin err++; $display("FAIL idle_cnt got %0d exp 1", ras_count); end
   endtask

   task automatic test_overflow();
      logic [11:0] exp_t;
      do_reset();
      for (int k = 1; k <= 9; k++) cyc(1'b1, 12'(k), 1'b0);
      vec++; if (ras_count !== 4'd8) begin err++; $display("FAIL ovf_cnt got %0d exp 8", ras_count); end
      vec++; if (ras_index !== 3'd1) begin err++; $display("FAIL ovf_idx got %0d exp 1", ras_index); end
      vec++; if (ret_target !== 12'h009) begin err++; $display("FAIL ovf_tgt got %h exp 009", ret_target); end
      for (int k = 0; k < 8; k++) begin
         exp_t = 12'(9 - k);
         vec++; if (ret_target !== exp_t) begin err++; $display("FAIL ovf_pop%0d got %h exp %h", k, ret_target, exp_t); end
         cyc(1'b0, 12'h000, 1'b1);
      end
      vec++; if (ras_count !== 4'd0) begin err++; $display("FAIL ovf_drain_cnt got %0d exp 0", ras_count); end
      vec++; if (ras_index !== 3'd1) begin err++; $display("FAIL ovf_drain_idx got %0d exp 1", ras_index); end
      vec++; if (ret_target !== 12'h009) begin err++; $display("FAIL ovf_overwritten got %h exp 009", ret_target); end
   endtask

   task automatic test_underflow();
      do_reset();
      cyc(1'b0, 12'h000, 1'b1);
      vec++; if (ras_index !== 3'd7) begin err++; $display("FAIL udf_idx got %0d exp 7", ras_index); end
      vec++; if (ras_count !== 4'd0) begin err++; $display("FAIL udf_cnt got %0d exp 0", ras_count); end
      vec++; if (ras_empty !== 1'b1) begin err++; $display("FAIL udf_empty got %b exp 1", ras_empty); end
      vec++; if (ret_target !== 12'h000) begin err++; $display("FAIL udf_tgt got %h exp 000", ret_target); end
      cyc(1'b1, 12'hABC, 1'b0);
      vec++; if (ras_index !== 3'd0) begin err++; $display("FAIL udf_push_idx got %0d exp 0", ras_index); end
      vec++; if (ras_count !== 4'd1) begin err++; $display("FAIL udf_push_cnt got %0d exp 1", ras_count); end
      vec++; if (ret_target !== 12'hABC) begin err++; $display("FAIL udf_push_tgt got %h exp abc", ret_target); end
   endtask

   task automatic test_coroutine();
      do_reset();
      cyc(1'b1, 12'h222, 1'b0);
      cyc(1'b1, 12'h333, 1'b0);
      link_valid = 1'b1;
      link_target = 12'h444;
      ret_valid = 1'b1;
      #1;
      vec++; if (ret_target !== 12'h333) begin err++; $display("FAIL co_same_tgt got %h exp 333", ret_target); end
      @(posedge CLK);
      #1;
      link_valid = 1'b0;
      ret_valid = 1'b0;
      vec++; if (ras_index !== 3'd2) begin err++; $display("FAIL co_idx got %0d exp 2", ras_index); end
      vec++; if (ras_count !== 4'd2) begin err++; $display("FAIL co_cnt got %0d exp 2", ras_count); end
      vec++; if (ret_target !== 12'h444) begin err++; $display("FAIL co_tgt got %h exp 444", ret_target); end
      cyc(1'b0, 12'h000, 1'b1);
      vec++; if (ret_target !== 12'h222) begin err++; $display("FAIL co_below_tgt got %h exp 222", ret_target); end
   endtask

   task automatic test_restore();
      do_reset();
      cyc(1'b1, 12'h00A, 1'b0);
      cyc(1'b1, 12'h00B, 1'b0);
      cyc(1'b1, 12'h00C, 1'b0);
      cyc(1'b1, 12'h00D, 1'b0);
      cyc(1'b1, 12'h00E, 1'b0);
      vec++; if (ras_index !== 3'd5) begin err++; $display("FAIL rst_pre_idx got %0d exp 5", ras_index); end
      upd(3'd3, 4'd3, 1'b1, 1'b0);
      vec++; if (ras_index !== 3'd3) begin err++; $display("FAIL rst_idx got %0d exp 3", ras_index); end
      vec++; if (ras_count !== 4'd3) begin err++; $display("FAIL rst_cnt got %0d exp 3", ras_count); end
      vec++; if (ret_target !== 12'h00C) begin err++; $display("FAIL rst_tgt got %h exp 00c", ret_target); end
      upd(3'd4, 4'd4, 1'b1, 1'b1);
      vec++; if (ret_target !== 12'h00D) begin err++; $display("FAIL rst_e4 got %h exp 00d", ret_target); end
      upd(3'd5, 4'd5, 1'b0, 1'b1);
      vec++; if (ret_target !== 12'h00E) begin err++; $display("FAIL rst_e5 got %h exp 00e", ret_target); end
      vec++; if (ras_count !== 4'd5) begin err++; $display("FAIL rst_pop_ignored_cnt got %0d exp 5", ras_count); end
      upd(3'd2, 4'd15, 1'b0, 1'b0);
      vec++; if (ras_count !== 4'd8) begin err++; $display("FAIL clamp_cnt got %0d exp 8", ras_count); end
      vec++; if (ras_index !== 3'd2) begin err++; $display("FAIL clamp_idx got %0d exp 2", ras_index); end
      upd(3'd0, 4'd0, 1'b0, 1'b0);
      vec++; if (ras_empty !== 1'b1) begin err++; $display("FAIL upd_empty got %b exp 1", ras_empty); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      link_valid = 1'b1;
      link_target = 12'h100;
      @(posedge CLK);
      #1;
      link_target = 12'h101;
      vec++; if (ras_index !== 3'd1) begin err++; $display("FAIL mid_pre_idx got %0d exp 1", ras_index); end
      #2;
      nRST = 1'b0;
      #1;
      vec++; if (ret_target !== 12'h000) begin err++; $display("FAIL mid_async_tgt got %h exp 000", ret_target); end
      vec++; if (ras_index !== 3'd0) begin err++; $display("FAIL mid_async_idx got %0d exp 0", ras_index); end
      vec++; if (ras_count !== 4'd0) begin err++; $display("FAIL mid_async_cnt got %0d exp 0", ras_count); end
      vec++; if (ras_empty !== 1'b1) begin err++; $display("FAIL mid_async_empty got %b exp 1", ras_empty); end
      @(posedge CLK);
      #1;
      vec++; if (ras_count !== 4'd0) begin err++; $display("FAIL mid_held_cnt got %0d exp 0", ras_count); end
      link_valid = 1'b0;
      @(negedge CLK);
      nRST = 1'b1;
      @(posedge CLK);
      #1;
      vec++; if (ras_index !== 3'd0) begin err++; $display("FAIL mid_post_idx got %0d exp 0", ras_index); end
      update_valid = 1'b1;
      update_ras_index = 3'd1;
      update_ras_count = 4'd1;
      @(negedge CLK);
      nRST = 1'b0;
      #1;
      nRST = 1'b1;
      update_valid = 1'b0;
      @(posedge CLK);
      #1;
      vec++; if (ras_index !== 3'd0) begin err++; $display("FAIL mid_upd_abort_idx got %0d exp 0", ras_index); end
      vec++; if (ret_target !== 12'h000) begin err++; $display("FAIL mid_upd_abort_tgt got %h exp 000", ret_target); end
   endtask

   initial begin
      test_reset();
      test_push_pop();
      test_idle();
      test_overflow();
      test_underflow();
      test_coroutine();
      test_restore();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule
